// File: rtl/mem_access_responder_pkg.sv
// Shared definitions for the load/store responder: funct3 width codes, FSM
// state type and byte-lane helpers used by both the top and the extender.
package mem_access_responder_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RAM_RD,
    MMIO_WAIT
  } mem_state_t;

  // Width is funct3[1:0]: 00 byte, 01 half, otherwise word.
  function automatic logic [3:0] byte_lanes(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] width, input logic [31:0] d);
    case (width)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_responder_load_extend.sv
// Combinational load extraction: picks the byte/half addressed by the
// captured offset and sign- or zero-extends it according to funct3.
module load_extend_unit
  import mem_access_responder_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (type_i)
      MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data_o = {24'h0, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_responder.sv
// EX/MEM load/store responder: RAM stores complete in place, RAM loads take
// one stall cycle, MMIO accesses hold the pipeline until ready or timeout.
module mem_access_responder
  import mem_access_responder_pkg::*;
#(
  parameter int          RAM_ADDR_W   = 14,
  parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
  parameter int          MMIO_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            mem_type_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic [31:0]           load_data_o,
  output logic                  load_valid_o,
  output logic                  misaligned_o,
  output logic                  bus_fault_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [3:0]            ram_we_o,
  output logic                  ram_re_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  mmio_valid_o,
  output logic                  mmio_write_o,
  output logic [31:0]           mmio_addr_o,
  output logic [3:0]            mmio_wstrb_o,
  output logic [31:0]           mmio_wdata_o,
  input  logic                  mmio_ready_i,
  input  logic [31:0]           mmio_rdata_i
);

  localparam int CNT_W = $clog2(MMIO_TIMEOUT + 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [2:0]        type_q;
  logic [1:0]        off_q;
  logic [31:0]       mmio_addr_q, mmio_wdata_q;
  logic [3:0]        mmio_wstrb_q;
  logic              mmio_write_q;
  logic              capture;

  logic        req, is_mmio, bad_align;
  logic [3:0]  lanes;
  logic [31:0] ext_word, ext_data;

  assign req       = mem_read_i | mem_write_i;
  assign is_mmio   = addr_i >= MMIO_BASE;
  assign lanes     = byte_lanes(mem_type_i[1:0], addr_i[1:0]);
  assign bad_align = is_misaligned(mem_type_i[1:0], addr_i[1:0]);

  assign ram_addr_o  = addr_i[RAM_ADDR_W+1:2];
  assign ram_wdata_o = replicate_wdata(mem_type_i[1:0], wdata_i);

  assign mmio_write_o = mmio_write_q;
  assign mmio_addr_o  = mmio_addr_q;
  assign mmio_wstrb_o = mmio_wstrb_q;
  assign mmio_wdata_o = mmio_wdata_q;
  assign load_data_o  = load_data_d;

  assign ext_word = (state_q == MMIO_WAIT) ? mmio_rdata_i : ram_rdata_i;

  load_extend_unit u_ext (
    .type_i  (type_q),
    .offset_i(off_q),
    .word_i  (ext_word),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    capture      = 1'b0;
    stall_o      = 1'b0;
    ram_re_o     = 1'b0;
    ram_we_o     = 4'b0000;
    misaligned_o = 1'b0;
    load_valid_o = 1'b0;
    bus_fault_o  = 1'b0;
    mmio_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad_align) begin
            misaligned_o = 1'b1;
          end else if (is_mmio) begin
            capture = 1'b1;
            stall_o = 1'b1;
            cnt_d   = '0;
            state_d = MMIO_WAIT;
          end else if (mem_write_i) begin
            ram_we_o = lanes;
          end else begin
            capture  = 1'b1;
            ram_re_o = 1'b1;
            stall_o  = 1'b1;
            state_d  = RAM_RD;
          end
        end
      end
      RAM_RD: begin
        load_valid_o = 1'b1;
        load_data_d  = ext_data;
        state_d      = IDLE;
      end
      MMIO_WAIT: begin
        mmio_valid_o = 1'b1;
        // Ready wins over a timeout landing in the same cycle.
        if (mmio_ready_i) begin
          if (!mmio_write_q) begin
            load_valid_o = 1'b1;
            load_data_d  = ext_data;
          end
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(MMIO_TIMEOUT)) begin
          bus_fault_o = 1'b1;
          load_data_d = '0;
          state_d     = IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  // Request attributes are frozen at issue; the pipeline may move underneath.
  always_ff @(posedge clk) begin
    if (capture) begin
      type_q       <= mem_type_i;
      off_q        <= addr_i[1:0];
      mmio_addr_q  <= addr_i;
      mmio_write_q <= mem_write_i;
      mmio_wstrb_q <= mem_write_i ? lanes : 4'b0000;
      mmio_wdata_q <= replicate_wdata(mem_type_i[1:0], wdata_i);
    end
  end

endmodule

// File: tb/tb_mem_access_responder.sv
// Directed bench for mem_access_responder with a behavioural one-cycle RAM.
module tb_mem_access_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  mem_type_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, load_valid_o, misaligned_o, bus_fault_o;
  logic [31:0] load_data_o;
  logic [13:0] ram_addr_o;
  logic [3:0]  ram_we_o;
  logic        ram_re_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        mmio_valid_o, mmio_write_o;
  logic [31:0] mmio_addr_o, mmio_wdata_o;
  logic [3:0]  mmio_wstrb_o;
  logic        mmio_ready_i;
  logic [31:0] mmio_rdata_i;

  int vecs = 0;
  int errs = 0;

  logic [31:0] ram_mem [0:16383];

  always #5 clk = ~clk;

  mem_access_responder dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_type_i(mem_type_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misaligned_o(misaligned_o), .bus_fault_o(bus_fault_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_re_o(ram_re_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .mmio_valid_o(mmio_valid_o), .mmio_write_o(mmio_write_o), .mmio_addr_o(mmio_addr_o),
    .mmio_wstrb_o(mmio_wstrb_o), .mmio_wdata_o(mmio_wdata_o),
    .mmio_ready_i(mmio_ready_i), .mmio_rdata_i(mmio_rdata_i)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we_o[i]) ram_mem[ram_addr_o][8*i +: 8] <= ram_wdata_o[8*i +: 8];
    if (ram_re_o) ram_rdata_i <= ram_mem[ram_addr_o];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vecs++;
    if ({stall_o, load_valid_o, mmio_valid_o, ram_re_o, misaligned_o, bus_fault_o, ram_we_o} !== 10'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b expected 0", {stall_o, load_valid_o, mmio_valid_o, ram_re_o, misaligned_o, bus_fault_o, ram_we_o});
    end
    vecs++;
    if (load_data_o !== 32'h0) begin errs++; $display("FAIL reset_data: got %h expected 0", load_data_o); end
  endtask

  task automatic test_ram_word();
    tick();
    mem_write_i = 1'b1; mem_type_i = 3'b010; addr_i = 32'h100; wdata_i = 32'hCAFEBABE;
    #1;
    vecs++;
    if (ram_we_o !== 4'b1111 || stall_o !== 1'b0) begin errs++; $display("FAIL sw_we: got we=%b stall=%b expected 1111/0", ram_we_o, stall_o); end
    vecs++;
    if (ram_addr_o !== 14'h040 || ram_wdata_o !== 32'hCAFEBABE) begin errs++; $display("FAIL sw_addr: got %h/%h expected 040/cafebabe", ram_addr_o, ram_wdata_o); end
    tick();
    mem_write_i = 1'b0; mem_read_i = 1'b1;
    #1;
    vecs++;
    if (stall_o !== 1'b1 || ram_re_o !== 1'b1 || load_valid_o !== 1'b0) begin errs++; $display("FAIL lw_issue: got stall=%b re=%b lv=%b expected 1/1/0", stall_o, ram_re_o, load_valid_o); end
    tick();
    vecs++;
    if (stall_o !== 1'b0 || load_valid_o !== 1'b1 || load_data_o !== 32'hCAFEBABE) begin errs++; $display("FAIL lw_data: got stall=%b lv=%b data=%h expected 0/1/cafebabe", stall_o, load_valid_o, load_data_o); end
    mem_read_i = 1'b0;
    tick();
    vecs++;
    if (load_valid_o !== 1'b0 || load_data_o !== 32'hCAFEBABE) begin errs++; $display("FAIL lw_hold: got lv=%b data=%h expected 0/cafebabe", load_valid_o, load_data_o); end
  endtask

  task automatic test_byte_half_b2b();
    mem_write_i = 1'b1; mem_type_i = 3'b000; addr_i = 32'h203; wdata_i = 32'h000000F0;
    #1;
    vecs++;
    if (ram_we_o !== 4'b1000 || ram_wdata_o !== 32'hF0F0F0F0) begin errs++; $display("FAIL sb_lanes: got we=%b wd=%h expected 1000/f0f0f0f0", ram_we_o, ram_wdata_o); end
    tick();
    mem_write_i = 1'b0; mem_read_i = 1'b1;
    tick();
    vecs++;
    if (load_valid_o !== 1'b1 || load_data_o !== 32'hFFFFFFF0) begin errs++; $display("FAIL lb_sext: got lv=%b data=%h expected 1/fffffff0", load_valid_o, load_data_o); end
    tick();
    mem_type_i = 3'b100;
    #1;
    vecs++;
    if (stall_o !== 1'b1 || ram_re_o !== 1'b1 || load_valid_o !== 1'b0) begin errs++; $display("FAIL b2b_issue: got stall=%b re=%b lv=%b expected 1/1/0", stall_o, ram_re_o, load_valid_o); end
    tick();
    vecs++;
    if (load_valid_o !== 1'b1 || load_data_o !== 32'h000000F0) begin errs++; $display("FAIL lbu_zext: got lv=%b data=%h expected 1/000000f0", load_valid_o, load_data_o); end
    mem_read_i = 1'b0;
    tick();
    mem_write_i = 1'b1; mem_type_i = 3'b001; addr_i = 32'h102; wdata_i = 32'h0000BEEF;
    #1;
    vecs++;
    if (ram_we_o !== 4'b1100 || ram_wdata_o !== 32'hBEEFBEEF) begin errs++; $display("FAIL sh_lanes: got we=%b wd=%h expected 1100/beefbeef", ram_we_o, ram_wdata_o); end
    tick();
    mem_write_i = 1'b0; mem_read_i = 1'b1;
    tick();
    vecs++;
    if (load_data_o !== 32'hFFFFBEEF) begin errs++; $display("FAIL lh_sext: got %h expected ffffbeef", load_data_o); end
    tick();
    mem_type_i = 3'b010; addr_i = 32'h100;
    tick();
    vecs++;
    if (load_valid_o !== 1'b1 || load_data_o !== 32'hBEEFBABE) begin errs++; $display("FAIL lw_merge: got lv=%b data=%h expected 1/beefbabe", load_valid_o, load_data_o); end
    mem_read_i = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    mem_read_i = 1'b1; mem_type_i = 3'b001; addr_i = 32'h101;
    #1;
    vecs++;
    if (misaligned_o !== 1'b1 || stall_o !== 1'b0 || ram_re_o !== 1'b0 || load_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL lh_misalign: got mis=%b stall=%b re=%b lv=%b expected 1/0/0/0", misaligned_o, stall_o, ram_re_o, load_valid_o);
    end
    tick();
    mem_read_i = 1'b0;
    #1;
    vecs++;
    if (misaligned_o !== 1'b0 || load_valid_o !== 1'b0 || stall_o !== 1'b0) begin errs++; $display("FAIL misalign_pulse: got mis=%b lv=%b stall=%b expected 0/0/0", misaligned_o, load_valid_o, stall_o); end
    mem_write_i = 1'b1; mem_type_i = 3'b010; addr_i = 32'h102;
    #1;
    vecs++;
    if (misaligned_o !== 1'b1 || ram_we_o !== 4'b0000) begin errs++; $display("FAIL sw_misalign: got mis=%b we=%b expected 1/0000", misaligned_o, ram_we_o); end
    tick();
    mem_write_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_read_i = 1'b1; mem_type_i = 3'b010; addr_i = 32'h8000_0030;
    tick();
    vecs++;
    if (mmio_valid_o !== 1'b1) begin errs++; $display("FAIL rstmid_valid: got %b expected 1", mmio_valid_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_read_i = 1'b0;
    #1;
    vecs++;
    if (stall_o !== 1'b0 || mmio_valid_o !== 1'b0 || load_data_o !== 32'h0) begin errs++; $display("FAIL rstmid_clear: got stall=%b mv=%b data=%h expected 0/0/0", stall_o, mmio_valid_o, load_data_o); end
    mmio_ready_i = 1'b1; mmio_rdata_i = 32'hDEADBEEF;
    #1;
    vecs++;
    if (load_valid_o !== 1'b0) begin errs++; $display("FAIL rstmid_late: got lv=%b expected 0", load_valid_o); end
    tick();
    mmio_ready_i = 1'b0;
    #1;
    vecs++;
    if (load_valid_o !== 1'b0 || load_data_o !== 32'h0) begin errs++; $display("FAIL rstmid_after: got lv=%b data=%h expected 0/0", load_valid_o, load_data_o); end
  endtask

  task automatic test_mmio_load();
    int stalls;
    tick();
    mem_read_i = 1'b1; mem_type_i = 3'b010; addr_i = 32'h8000_0010;
    #1;
    vecs++;
    if (stall_o !== 1'b1 || mmio_valid_o !== 1'b0 || ram_re_o !== 1'b0) begin errs++; $display("FAIL mmio_issue: got stall=%b mv=%b re=%b expected 1/0/0", stall_o, mmio_valid_o, ram_re_o); end
    stalls = int'(stall_o);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (mmio_valid_o !== 1'b1 || stall_o !== 1'b1 || mmio_addr_o !== 32'h8000_0010 || mmio_write_o !== 1'b0) begin
        errs++;
        $display("FAIL mmio_wait%0d: got mv=%b stall=%b addr=%h wr=%b expected 1/1/80000010/0", i, mmio_valid_o, stall_o, mmio_addr_o, mmio_write_o);
      end
      stalls += int'(stall_o);
    end
    tick();
    mmio_ready_i = 1'b1; mmio_rdata_i = 32'h12345678;
    #1;
    vecs++;
    if (stall_o !== 1'b0 || load_valid_o !== 1'b1 || load_data_o !== 32'h12345678) begin errs++; $display("FAIL mmio_done: got stall=%b lv=%b data=%h expected 0/1/12345678", stall_o, load_valid_o, load_data_o); end
    vecs++;
    if (stalls != 4) begin errs++; $display("FAIL mmio_stall_len: got %0d expected 4", stalls); end
    mem_read_i = 1'b0;
    tick();
    mmio_ready_i = 1'b0;
    #1;
    vecs++;
    if (mmio_valid_o !== 1'b0 || load_valid_o !== 1'b0 || load_data_o !== 32'h12345678) begin errs++; $display("FAIL mmio_hold: got mv=%b lv=%b data=%h expected 0/0/12345678", mmio_valid_o, load_valid_o, load_data_o); end
  endtask

  task automatic test_mmio_store();
    mem_write_i = 1'b1; mem_type_i = 3'b000; addr_i = 32'h8000_0005; wdata_i = 32'h000000A5;
    #1;
    vecs++;
    if (stall_o !== 1'b1 || ram_we_o !== 4'b0000) begin errs++; $display("FAIL mmio_st_issue: got stall=%b we=%b expected 1/0000", stall_o, ram_we_o); end
    tick();
    vecs++;
    if (mmio_valid_o !== 1'b1 || mmio_write_o !== 1'b1 || mmio_wstrb_o !== 4'b0010 || mmio_wdata_o !== 32'hA5A5A5A5 || mmio_addr_o !== 32'h8000_0005) begin
      errs++;
      $display("FAIL mmio_st_bus: got mv=%b wr=%b strb=%b wd=%h addr=%h expected 1/1/0010/a5a5a5a5/80000005", mmio_valid_o, mmio_write_o, mmio_wstrb_o, mmio_wdata_o, mmio_addr_o);
    end
    mmio_ready_i = 1'b1;
    #1;
    vecs++;
    if (stall_o !== 1'b0 || load_valid_o !== 1'b0) begin errs++; $display("FAIL mmio_st_done: got stall=%b lv=%b expected 0/0", stall_o, load_valid_o); end
    mem_write_i = 1'b0;
    tick();
    mmio_ready_i = 1'b0;
    #1;
    vecs++;
    if (mmio_valid_o !== 1'b0 || load_data_o !== 32'h12345678) begin errs++; $display("FAIL mmio_st_after: got mv=%b data=%h expected 0/12345678", mmio_valid_o, load_data_o); end
  endtask

  task automatic test_timeout();
    int  waits;
    logic seen;
    waits = 0;
    seen  = 1'b0;
    mem_read_i = 1'b1; mem_type_i = 3'b010; addr_i = 32'h8000_0020; mmio_ready_i = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (bus_fault_o) seen = 1'b1;
      else if (stall_o && mmio_valid_o) waits++;
    end
    vecs++;
    if (seen !== 1'b1) begin errs++; $display("FAIL timeout_seen: got %b expected 1", seen); end
    vecs++;
    if (waits != 255) begin errs++; $display("FAIL timeout_len: got %0d expected 255", waits); end
    vecs++;
    if (stall_o !== 1'b0 || load_data_o !== 32'h0 || load_valid_o !== 1'b0) begin errs++; $display("FAIL timeout_out: got stall=%b data=%h lv=%b expected 0/0/0", stall_o, load_data_o, load_valid_o); end
    mem_read_i = 1'b0;
    tick();
    vecs++;
    if (bus_fault_o !== 1'b0 || stall_o !== 1'b0 || mmio_valid_o !== 1'b0 || load_data_o !== 32'h0) begin
      errs++;
      $display("FAIL timeout_after: got bf=%b stall=%b mv=%b data=%h expected 0/0/0/0", bus_fault_o, stall_o, mmio_valid_o, load_data_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram_mem[i] = 32'h0;
    ram_rdata_i  = 32'h0;
    rst          = 1'b1;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    mem_type_i   = 3'b010;
    addr_i       = 32'h0;
    wdata_i      = 32'h0;
    mmio_ready_i = 1'b0;
    mmio_rdata_i = 32'h0;
    test_reset();
    test_ram_word();
    test_byte_half_b2b();
    test_misaligned();
    test_reset_mid();
    test_mmio_load();
    test_mmio_store();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Services the load/store request carried in the EX/MEM stage: mem_read, mem_write, mem_type and the ALU-computed address.
- Drives a single-cycle-latency synchronous data RAM and a valid/ready MMIO bus.
- Returns aligned, sign- or zero-extended load data to write-back.
- Raises a pipeline stall while a request is outstanding. Flags misaligned accesses and MMIO timeouts.

Parameters:
- RAM_ADDR_W, 14, word-address width of data RAM (64 KiB).
- MMIO_BASE, 32'h8000_0000, addresses at or above this go to MMIO; below go to RAM.
- MMIO_TIMEOUT, 255, maximum wait cycles for mmio_ready before bus fault.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_read_i  in  1  load request from EX/MEM
- mem_write_i  in  1  store request from EX/MEM
- mem_type_i  in  3  RISC-V funct3 width/sign code
- addr_i  in  32  byte address
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- load_data_o  out  32  extended load result, valid when load_valid_o
- load_valid_o  out  1  one-cycle pulse, load completed
- misaligned_o  out  1  one-cycle pulse, misaligned access rejected
- bus_fault_o  out  1  one-cycle pulse, MMIO timeout
- ram_addr_o  out  RAM_ADDR_W  word address to RAM
- ram_we_o  out  4  byte write enables
- ram_re_o  out  1  RAM read enable
- ram_wdata_o  out  32  lane-replicated store data
- ram_rdata_i  in  32  RAM read data, one cycle after ram_re_o
- mmio_valid_o  out  1  MMIO request valid
- mmio_write_o  out  1  MMIO direction
- mmio_addr_o  out  32  MMIO byte address
- mmio_wstrb_o  out  4  MMIO byte strobes
- mmio_wdata_o  out  32  MMIO store data
- mmio_ready_i  in  1  MMIO accept/complete
- mmio_rdata_i  in  32  MMIO read data, valid with mmio_ready_i

Behaviour:
- Reset (rst high at posedge):
  - state IDLE, timeout counter 0, load_data_o 0.
  - All pulses, stall_o, enables and mmio_valid_o are 0.
  - Reset mid-transaction abandons it; any MMIO response arriving afterwards is ignored.
- Request: mem_read_i | mem_write_i in IDLE. Both high is treated as a write.
- Alignment:
  - Half-word requires addr[0]==0; word requires addr[1:0]==0.
  - A violation pulses misaligned_o that cycle. No RAM/MMIO access, no stall, no load_valid_o.
- Byte lanes:
  - ram_we_o / mmio_wstrb_o: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111.
  - wdata is replicated: byte x4, half x2.
- Load extract:
  - Select byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is a pass-through.
  - Offset and type are captured at issue, because the pipeline is frozen but captured copies are used regardless.
- FSM states: IDLE, RAM_RD, MMIO_WAIT.
- IDLE, RAM store: ram_we_o asserted combinationally, stall_o=0, stays IDLE. Latency 0 extra cycles.
- IDLE, RAM load: ram_re_o=1, stall_o=1, goes to RAM_RD.
- RAM_RD: stall_o=0; load_data_o registered from ram_rdata_i at the end of this cycle; load_valid_o pulses the following cycle; goes to IDLE. The pipeline advances at the end of RAM_RD; the same request is not re-issued because RAM_RD returns to IDLE at that edge.
  - Correction, normative: load_data_o is driven combinationally from ram_rdata_i in RAM_RD with load_valid_o=1 that cycle, and is also registered so it holds until the next load.
- IDLE, MMIO access: register address, strobes and data; goes to MMIO_WAIT; stall_o=1.
- MMIO_WAIT:
  - mmio_valid_o=1 and stall_o=1 until mmio_ready_i.
  - On ready: a load presents extended mmio_rdata_i with load_valid_o=1, stall_o drops that cycle, goes to IDLE.
  - Counter increments each waiting cycle. When it reaches MMIO_TIMEOUT: bus_fault_o pulses, load_data_o=0, stall_o drops, goes to IDLE.
- mmio_* outputs stay constant while waiting.
- Back-to-back loads: a second load issues in the first IDLE cycle after completion; one bubble per RAM load.

Decomposition:
- common_def holds:
  - mem_type codes MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101;
  - state enum mem_state_t;
  - MMIO_BASE default.
- One sub-module, load_extend_unit: combinational extraction and extension from (type, offset, word).

Test Plan:
- SW 32'hCAFEBABE @0x100, then LW @0x100: ram_we_o=4'b1111, then load_data_o=32'hCAFEBABE with one stall cycle.
- SB 32'h000000F0 @0x203, then LB @0x203 and LBU @0x203: ram_we_o=4'b1000; LB gives 32'hFFFFFFF0, LBU gives 32'h000000F0.
- LH @0x101: misaligned_o pulses once, stall_o stays 0, no ram_re_o, no load_valid_o.
- LW @0x8000_0010 with mmio_ready_i after 3 cycles, rdata 32'h12345678: stall_o high for 4 cycles, then load_data_o=32'h12345678.
- MMIO load with ready never asserted: bus_fault_o pulses after 255 wait cycles, stall_o releases, load_data_o=0.
- rst asserted during MMIO_WAIT, then late mmio_ready_i: all outputs 0, state IDLE, late ready produces no load_valid_o.
